cache_write_buffer: RTL and testbench

- Posted-write buffer between a cache's next-level master side and the next-level memory.
- Absorbs cache write/evict traffic into a small FIFO and drains it to memory when the memory path is otherwise idle.
- Serves cache reads that hit a buffered address directly (store-to-load forwarding) and forwards read misses downstream.
- One instance per cache: data and instruction.

---
 rtl/cachepkg.sv | 11 +
 rtl/cache_write_buffer_match.sv | 39 +++
 rtl/cache_write_buffer.sv | 211 +++++++++++++++++++++
 tb/tb_cache_write_buffer.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cachepkg.sv
// Shared types for the cache write buffer: FSM state encoding.
package cachepkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    RD_REQ  = 2'd2,
    RD_WAIT = 2'd3
  } wb_state_t;

endpackage

// File: rtl/cache_write_buffer_match.sv
// Combinational address lookup across all buffer entries.
// When several entries match, the most recently enqueued one (closest behind tail) wins.
module cache_write_buffer_match
  import cachepkg::*;
#(
  parameter int DATAWIDTH    = 32,
  parameter int ADDRESSWIDTH = 32,
  parameter int DEPTH        = 4,
  parameter int PW           = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]                   valid_i,
  input  logic [DEPTH-1:0][ADDRESSWIDTH-1:0] addr_i,
  input  logic [DEPTH-1:0][DATAWIDTH-1:0]    data_i,
  input  logic [PW-1:0]                      tail_i,
  input  logic [ADDRESSWIDTH-1:0]            lookup_addr_i,
  output logic                               hit_o,
  output logic [PW-1:0]                      hit_idx_o,
  output logic [DATAWIDTH-1:0]               hit_data_o
);

  logic [PW-1:0] idx_s;

  // Walk oldest to newest so a later (newer) match overrides an earlier one.
  always_comb begin
    hit_o      = 1'b0;
    hit_idx_o  = '0;
    hit_data_o = '0;
    idx_s      = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      idx_s = tail_i - PW'(k + 1);
      if (valid_i[idx_s] && (addr_i[idx_s] == lookup_addr_i)) begin
        hit_o      = 1'b1;
        hit_idx_o  = idx_s;
        hit_data_o = data_i[idx_s];
      end
    end
  end

endmodule

// File: rtl/cache_write_buffer.sv
// Posted-write buffer between a cache and next-level memory: coalesces writes,
// forwards read hits from buffered data, and drains to memory when otherwise idle.
module cache_write_buffer
  import cachepkg::*;
#(
  parameter int DATAWIDTH    = 32,
  parameter int ADDRESSWIDTH = 32,
  parameter int DEPTH        = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDRESSWIDTH-1:0] req_addr,
  input  logic [DATAWIDTH-1:0]    req_wdata,
  output logic                    rsp_valid,
  output logic [DATAWIDTH-1:0]    rsp_rdata,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_write,
  output logic [ADDRESSWIDTH-1:0] mem_addr,
  output logic [DATAWIDTH-1:0]    mem_wdata,
  input  logic                    mem_rsp_valid,
  input  logic [DATAWIDTH-1:0]    mem_rsp_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic                    valid;
    logic [ADDRESSWIDTH-1:0] addr;
    logic [DATAWIDTH-1:0]    data;
  } wb_entry_t;

  wb_state_t                 state_q, state_d;
  logic [CW-1:0]             count_q, count_d;
  logic [PW-1:0]             head_q, head_d;
  logic [PW-1:0]             tail_q, tail_d;
  wb_entry_t [DEPTH-1:0]     entry_q, entry_d;
  logic [ADDRESSWIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [DATAWIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;

  logic [DEPTH-1:0]                   ent_valid_s;
  logic [DEPTH-1:0][ADDRESSWIDTH-1:0] ent_addr_s;
  logic [DEPTH-1:0][DATAWIDTH-1:0]    ent_data_s;
  logic                               hit_s;
  logic [PW-1:0]                      hit_idx_s;
  logic [DATAWIDTH-1:0]               hit_data_s;
  logic                               full_s;
  logic                               req_ready_s;
  logic                               req_fire_s;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid_s[i] = entry_q[i].valid;
      ent_addr_s[i]  = entry_q[i].addr;
      ent_data_s[i]  = entry_q[i].data;
    end
  end

  cache_write_buffer_match #(
    .DATAWIDTH   (DATAWIDTH),
    .ADDRESSWIDTH(ADDRESSWIDTH),
    .DEPTH       (DEPTH),
    .PW          (PW)
  ) u_match (
    .valid_i      (ent_valid_s),
    .addr_i       (ent_addr_s),
    .data_i       (ent_data_s),
    .tail_i       (tail_q),
    .lookup_addr_i(req_addr),
    .hit_o        (hit_s),
    .hit_idx_o    (hit_idx_s),
    .hit_data_o   (hit_data_s)
  );

  assign full_s = (count_q == CW'(DEPTH));

  // A full buffer still takes a write that coalesces into an existing entry.
  always_comb begin
    req_ready_s = 1'b0;
    if (reset && (state_q == IDLE)) begin
      req_ready_s = !req_write || !full_s || hit_s;
    end else begin
      req_ready_s = 1'b0;
    end
  end

  assign req_ready  = req_ready_s;
  assign req_fire_s = req_valid && req_ready_s;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    head_d      = head_q;
    tail_d      = tail_q;
    entry_d     = entry_q;
    rd_addr_d   = rd_addr_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (req_fire_s) begin
          if (req_write) begin
            if (hit_s) begin
              entry_d[hit_idx_s].data = req_wdata;
            end else begin
              entry_d[tail_q].valid = 1'b1;
              entry_d[tail_q].addr  = req_addr;
              entry_d[tail_q].data  = req_wdata;
              tail_d                = tail_q + PW'(1);
              count_d               = count_q + CW'(1);
            end
          end else if (hit_s) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = hit_data_s;
          end else begin
            rd_addr_d = req_addr;
            state_d   = RD_REQ;
          end
        end else if (count_q != '0) begin
          // Also covers a write refused because the buffer is full.
          state_d = DRAIN;
        end else begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (mem_req_ready) begin
          entry_d[head_q].valid = 1'b0;
          head_d                = head_q + PW'(1);
          count_d               = count_q - CW'(1);
          state_d               = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      RD_REQ: begin
        if (mem_req_ready) begin
          state_d = RD_WAIT;
        end else begin
          state_d = RD_REQ;
        end
      end
      RD_WAIT: begin
        if (mem_rsp_valid) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = mem_rsp_rdata;
          state_d     = IDLE;
        end else begin
          state_d = RD_WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory request is decoded from registered state, so reset removes it at once.
  always_comb begin
    mem_req_valid = 1'b0;
    mem_write     = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    case (state_q)
      DRAIN: begin
        mem_req_valid = 1'b1;
        mem_write     = 1'b1;
        mem_addr      = entry_q[head_q].addr;
        mem_wdata     = entry_q[head_q].data;
      end
      RD_REQ: begin
        mem_req_valid = 1'b1;
        mem_addr      = rd_addr_q;
      end
      default: begin
        mem_req_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      entry_q     <= '0;
      rd_addr_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      entry_q     <= entry_d;
      rd_addr_q   <= rd_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_cache_write_buffer.sv
// Scenario bench for cache_write_buffer: memory writes and read responses are
// checked against scoreboard queues filled as stimulus is driven.
module tb_cache_write_buffer;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          mem_req_valid, mem_req_ready, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_rdata;

  int checks   = 0;
  int failures = 0;
  int wr_seen  = 0;
  int rd_vis   = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_wr_q[$];
  logic [DW-1:0] exp_rsp_q[$];
  wr_t           mon_wr;
  logic [DW-1:0] mon_rsp;

  cache_write_buffer #(.DATAWIDTH(DW), .ADDRESSWIDTH(AW), .DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_rdata(mem_rsp_rdata)
  );

  always #5 clock = ~clock;

  // Inputs change just after the rising edge, so the falling edge sees what the next edge will capture.
  always @(negedge clock) begin
    if (reset) begin
      if (mem_req_valid && mem_req_ready && mem_write) begin
        wr_seen++;
        checks++;
        if (exp_wr_q.size() == 0) begin
          failures++;
          $display("FAIL mem_write_unexpected: got addr=%h data=%h, required no write", mem_addr, mem_wdata);
        end else begin
          mon_wr = exp_wr_q.pop_front();
          if (mem_addr !== mon_wr.addr || mem_wdata !== mon_wr.data) begin
            failures++;
            $display("FAIL mem_write_order: got addr=%h data=%h, required addr=%h data=%h",
                     mem_addr, mem_wdata, mon_wr.addr, mon_wr.data);
          end
        end
      end
      if (mem_req_valid && !mem_write) rd_vis++;
      if (rsp_valid) begin
        checks++;
        if (exp_rsp_q.size() == 0) begin
          failures++;
          $display("FAIL rsp_unexpected: got rsp_rdata=%h, required no response", rsp_rdata);
        end else begin
          mon_rsp = exp_rsp_q.pop_front();
          if (rsp_rdata !== mon_rsp) begin
            failures++;
            $display("FAIL rsp_data: got %h, required %h", rsp_rdata, mon_rsp);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset         = 1'b0;
    req_valid     = 1'b0;
    req_write     = 1'b0;
    req_addr      = '0;
    req_wdata     = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, output int waits);
    waits     = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    #1;
    while (!req_ready && waits < 40) begin
      step();
      #1;
      waits++;
    end
    checks++;
    if (!req_ready) begin
      failures++;
      $display("FAIL handshake_timeout: got req_ready=%b after %0d cycles, required 1", req_ready, waits);
    end
    step();
  endtask

  task automatic idle_req();
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic drain_all(input int budget);
    int n = 0;
    mem_req_ready = 1'b1;
    while (exp_wr_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    repeat (3) step();
    mem_req_ready = 1'b0;
    checks++;
    if (exp_wr_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: got %0d writes outstanding, required 0", exp_wr_q.size());
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h10;
    req_wdata = 32'h1;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    step();
    checks++;
    if ({req_ready, rsp_valid, mem_req_valid, mem_write} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl: got %b, required 0000", {req_ready, rsp_valid, mem_req_valid, mem_write});
    end
    checks++;
    if ({mem_addr, mem_wdata, rsp_rdata} !== {(AW + 2 * DW){1'b0}}) begin
      failures++;
      $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h, required 0", mem_addr, mem_wdata, rsp_rdata);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset: got %b, required 1", req_ready);
    end
    idle_req();
    step();
  endtask

  task automatic test_read_hit();
    int w;
    int rd0;
    apply_reset();
    rd0 = rd_vis;
    send(1'b1, 32'h100, 32'hAAAA, w);
    send(1'b1, 32'h104, 32'hBBBB, w);
    send(1'b1, 32'h108, 32'hCCCC, w);
    exp_rsp_q.push_back(32'hBBBB);
    send(1'b0, 32'h104, 32'h0, w);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hBBBB) begin
      failures++;
      $display("FAIL read_hit: got valid=%b data=%h, required valid=1 data=0000bbbb", rsp_valid, rsp_rdata);
    end
    idle_req();
    step();
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rsp_pulse: got rsp_valid=%b, required 0", rsp_valid);
    end
    for (int c = 0; c < 2; c++) begin
      checks++;
      if ({mem_req_valid, mem_write, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h100, 32'hAAAA}) begin
        failures++;
        $display("FAIL drain_head_held: got v=%b w=%b addr=%h data=%h, required v=1 w=1 addr=100 data=aaaa",
                 mem_req_valid, mem_write, mem_addr, mem_wdata);
      end
      step();
    end
    exp_wr_q.push_back('{addr: 32'h100, data: 32'hAAAA});
    exp_wr_q.push_back('{addr: 32'h104, data: 32'hBBBB});
    exp_wr_q.push_back('{addr: 32'h108, data: 32'hCCCC});
    drain_all(40);
    checks++;
    if (rd_vis != rd0) begin
      failures++;
      $display("FAIL hit_no_mem_read: got %0d read cycles, required 0", rd_vis - rd0);
    end
  endtask

  task automatic test_coalesce();
    int w;
    int wr0;
    apply_reset();
    wr0 = wr_seen;
    send(1'b1, 32'h100, 32'h1111, w);
    send(1'b1, 32'h100, 32'h2222, w);
    idle_req();
    exp_wr_q.push_back('{addr: 32'h100, data: 32'h2222});
    drain_all(20);
    checks++;
    if (wr_seen - wr0 != 1) begin
      failures++;
      $display("FAIL coalesce_count: got %0d memory writes, required 1", wr_seen - wr0);
    end
  endtask

  task automatic test_full_stall();
    int w;
    apply_reset();
    for (int i = 0; i < DEPTH; i++) begin
      send(1'b1, 32'h10 + 32'(4 * i), 32'h100 + 32'(i), w);
      exp_wr_q.push_back('{addr: 32'h10 + 32'(4 * i), data: 32'h100 + 32'(i)});
    end
    exp_wr_q.push_back('{addr: 32'h200, data: 32'h2000});
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h200;
    req_wdata = 32'h2000;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_refuse: got req_ready=%b, required 0", req_ready);
    end
    step();
    checks++;
    if ({req_ready, mem_req_valid, mem_write, mem_addr} !== {1'b0, 1'b1, 1'b1, 32'h10}) begin
      failures++;
      $display("FAIL full_drain: got ready=%b v=%b w=%b addr=%h, required ready=0 v=1 w=1 addr=10",
               req_ready, mem_req_valid, mem_write, mem_addr);
    end
    mem_req_ready = 1'b1;
    send(1'b1, 32'h200, 32'h2000, w);
    checks++;
    if (w != 1) begin
      failures++;
      $display("FAIL accept_after_pop: got %0d wait cycles, required 1", w);
    end
    idle_req();
    drain_all(40);
  endtask

  task automatic test_read_miss();
    int w;
    apply_reset();
    send(1'b1, 32'h50, 32'h5050, w);
    send(1'b0, 32'h300, 32'h0, w);
    idle_req();
    checks++;
    if ({mem_req_valid, mem_write, mem_addr} !== {1'b1, 1'b0, 32'h300}) begin
      failures++;
      $display("FAIL miss_req: got v=%b w=%b addr=%h, required v=1 w=0 addr=300", mem_req_valid, mem_write, mem_addr);
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'hBAD;
    step();
    mem_rsp_valid = 1'b0;
    checks++;
    if ({rsp_valid, mem_req_valid, mem_write, mem_addr} !== {1'b0, 1'b1, 1'b0, 32'h300}) begin
      failures++;
      $display("FAIL stray_rsp_ignored: got rsp=%b v=%b w=%b addr=%h, required rsp=0 v=1 w=0 addr=300",
               rsp_valid, mem_req_valid, mem_write, mem_addr);
    end
    exp_rsp_q.push_back(32'hDEAD);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (mem_req_valid !== 1'b0 || rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL rd_wait_quiet: got mem_req_valid=%b rsp_valid=%b, required 0 0", mem_req_valid, rsp_valid);
      end
      step();
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'hDEAD;
    step();
    mem_rsp_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD) begin
      failures++;
      $display("FAIL miss_rsp: got valid=%b data=%h, required valid=1 data=0000dead", rsp_valid, rsp_rdata);
    end
    exp_wr_q.push_back('{addr: 32'h50, data: 32'h5050});
    drain_all(20);
  endtask

  task automatic test_wrap();
    int w;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      exp_wr_q.push_back('{addr: 32'h400 + 32'(4 * i), data: 32'hA000_0000 + 32'(i * 17)});
    end
    mem_req_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(1'b1, 32'h400 + 32'(4 * i), 32'hA000_0000 + 32'(i * 17), w);
    end
    idle_req();
    drain_all(80);
  endtask

  task automatic test_reset_in_drain();
    int w;
    int wr0;
    apply_reset();
    send(1'b1, 32'h600, 32'h6666, w);
    send(1'b1, 32'h604, 32'h7777, w);
    idle_req();
    step();
    checks++;
    if (mem_req_valid !== 1'b1 || mem_write !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_drain: got v=%b w=%b, required v=1 w=1", mem_req_valid, mem_write);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({mem_req_valid, mem_write, mem_addr, mem_wdata} !== {(2 + AW + DW){1'b0}}) begin
      failures++;
      $display("FAIL async_reset_drop: got v=%b w=%b addr=%h data=%h, required all 0",
               mem_req_valid, mem_write, mem_addr, mem_wdata);
    end
    step();
    reset = 1'b1;
    wr0 = wr_seen;
    send(1'b0, 32'h600, 32'h0, w);
    idle_req();
    checks++;
    if ({rsp_valid, mem_req_valid, mem_write, mem_addr} !== {1'b0, 1'b1, 1'b0, 32'h600}) begin
      failures++;
      $display("FAIL post_reset_miss: got rsp=%b v=%b w=%b addr=%h, required rsp=0 v=1 w=0 addr=600",
               rsp_valid, mem_req_valid, mem_write, mem_addr);
    end
    exp_rsp_q.push_back(32'h1234);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    step();
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h1234;
    step();
    mem_rsp_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234) begin
      failures++;
      $display("FAIL post_reset_rsp: got valid=%b data=%h, required valid=1 data=00001234", rsp_valid, rsp_rdata);
    end
    mem_req_ready = 1'b1;
    repeat (8) step();
    mem_req_ready = 1'b0;
    checks++;
    if (wr_seen != wr0) begin
      failures++;
      $display("FAIL discarded_writes: got %0d writes after reset, required 0", wr_seen - wr0);
    end
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_coalesce();
    test_full_stall();
    test_read_miss();
    test_wrap();
    test_reset_in_drain();
    checks++;
    if (exp_rsp_q.size() != 0) begin
      failures++;
      $display("FAIL rsp_outstanding: got %0d responses missing, required 0", exp_rsp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
